// File: rtl/ifq_pkg.sv
// Shared widths, FSM states and line-entry layout for the instruction fetch queue.
package ifq_pkg;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BYTES     = 16;
  localparam int LINE_PC_W      = 28;

  typedef enum logic {FETCH = 1'b0, REDIRECT = 1'b1} ifq_state_e;

  typedef struct packed {
    logic [LINE_W-1:0]    line;
    logic [LINE_PC_W-1:0] line_pc;
  } line_entry_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0] idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/ifq_line_fifo.sv
// Line buffer for fetched cache lines: DEPTH entries of {line, line_pc}, flushable,
// with asynchronous clear of pointers and occupancy.
module ifq_line_fifo import ifq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  line_entry_t            wr_data,
  input  logic                   rd_en,
  output line_entry_t            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  line_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd, full;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_wr   = wr_en && !flush;
  assign do_rd   = rd_en && !flush && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(do_wr && full));
endmodule

// File: rtl/ifq_ctrl.sv
// Instruction fetch queue controller: issues line fetches, buffers returned lines and
// hands out 32-bit instructions. Define IFQ_PERF_CNT_EN to add flush/empty counters.
module ifq_ctrl import ifq_pkg::*; #(
  parameter int          DEPTH     = 4,
  parameter int          CACHE_LAT = 1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  icache_pc_out,
  output logic         icache_rd_en,
  output logic         icache_abort,
  input  logic [127:0] icache_dout,
  input  logic         icache_dout_valid,
  input  logic         branch_valid,
  input  logic [31:0]  branch_target,
  input  logic         dq_rd_en,
  output logic [31:0]  dq_instr,
  output logic [31:0]  dq_pc,
  output logic         dq_empty
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]  perf_flush_cnt,
  output logic [31:0]  perf_empty_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e           state_q, state_d;
  logic [LINE_PC_W-1:0] fetch_line, fill_pc;
  logic [1:0]           wp;
  logic                 inflight;
  logic [CW-1:0]        count;
  logic [CW:0]          credit;
  logic                 fifo_empty, fill, consume, pop;
  line_entry_t          wr_entry, head;
  logic                 unused_tgt;

  assign unused_tgt = ^branch_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    icache_abort = 1'b0;
    unique case (state_q)
      FETCH:    if (branch_valid) state_d = REDIRECT;
      REDIRECT: begin
        state_d      = FETCH;
        icache_abort = 1'b1;
      end
      default:  state_d = FETCH;
    endcase
  end

  // Credit covers buffered lines plus the one read that may still be on its way back.
  assign credit        = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign icache_rd_en  = !rst && (state_q == FETCH) && !branch_valid &&
                         (credit < (CW+1)'(DEPTH));
  assign icache_pc_out = {fetch_line, 4'h0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               fetch_line <= RESET_PC[31:4];
    else if (branch_valid) fetch_line <= branch_target[31:4];
    else if (icache_rd_en) fetch_line <= fetch_line + 1'b1;
  end

  generate
    if (CACHE_LAT == 0) begin : g_lat0
      assign inflight = 1'b0;
      assign fill_pc  = fetch_line;
    end else begin : g_lat1
      logic [LINE_PC_W-1:0] pend_line;
      assign fill_pc = pend_line;
      // A return during a redirect is dropped but still frees its credit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          inflight  <= 1'b0;
          pend_line <= '0;
        end else if (icache_rd_en) begin
          inflight  <= 1'b1;
          pend_line <= fetch_line;
        end else if (icache_dout_valid || state_q == REDIRECT) begin
          inflight  <= 1'b0;
        end
      end
    end
  endgenerate

  assign fill             = icache_dout_valid && (state_q == FETCH) && !branch_valid;
  assign wr_entry.line    = icache_dout;
  assign wr_entry.line_pc = fill_pc;

  assign consume = dq_rd_en && !fifo_empty && !branch_valid;
  assign pop     = consume && (wp == 2'd3);

  ifq_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_valid),
    .wr_en   (fill),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .empty   (fifo_empty)
  );

  // The redirect word offset only affects the first line; wrapping 3->0 handles the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               wp <= 2'd0;
    else if (branch_valid) wp <= branch_target[3:2];
    else if (consume)      wp <= wp + 2'd1;
  end

  assign dq_empty = fifo_empty;
  assign dq_instr = fifo_empty ? 32'h0 : line_word(head.line, wp);
  assign dq_pc    = fifo_empty ? 32'h0 : {head.line_pc, wp, 2'b00};

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_flush_cnt <= '0;
      perf_empty_cnt <= '0;
    end else begin
      if (branch_valid && perf_flush_cnt != 32'hFFFF_FFFF) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (dq_empty && perf_empty_cnt != 32'hFFFF_FFFF)     perf_empty_cnt <= perf_empty_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ifq_ctrl.sv
// Bench for ifq_ctrl: vector table for priming/streaming, directed redirect/wrap/reset
// sequences, then random traffic against a line-occupancy and program-order model.
module tb_ifq_ctrl;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  icache_pc_out;
  logic         icache_rd_en, icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic         branch_valid;
  logic [31:0]  branch_target;
  logic         dq_rd_en;
  logic [31:0]  dq_instr, dq_pc;
  logic         dq_empty;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0]  perf_flush_cnt, perf_empty_cnt;
`endif

  int checks = 0;
  int passed = 0;

  ifq_ctrl #(.DEPTH(DEPTH), .CACHE_LAT(1), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_pc_out     (icache_pc_out),
    .icache_rd_en      (icache_rd_en),
    .icache_abort      (icache_abort),
    .icache_dout       (icache_dout),
    .icache_dout_valid (icache_dout_valid),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .dq_rd_en          (dq_rd_en),
    .dq_instr          (dq_instr),
    .dq_pc             (dq_pc),
    .dq_empty          (dq_empty)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_flush_cnt    (perf_flush_cnt),
    .perf_empty_cnt    (perf_empty_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] mkline(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = ins(a + 32'(4*k));
    return l;
  endfunction

  // One-cycle-latency cache: every request returns next cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icache_dout_valid <= 1'b0;
      icache_dout       <= '0;
    end else begin
      icache_dout_valid <= icache_rd_en;
      icache_dout       <= mkline(icache_pc_out);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic        exp_rd_en;
    logic [31:0] exp_pc_out;
    logic        exp_empty;
    logic [31:0] exp_dq_pc;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          q[$];
    int          now, gap, consumed, nbr;
    logic        br, prev_br, exp_empty, exp_rd;
    logic [31:0] tgt, exp_pc, exp_fetch;

    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h20, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h30, 1'b0, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h40, 1'b0, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h40, 1'b0, 32'h00};
    tbl[6]  = '{1'b1, 1'b0, 32'h40, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 1'b0, 32'h40, 1'b0, 32'h04};
    tbl[8]  = '{1'b1, 1'b0, 32'h40, 1'b0, 32'h08};
    tbl[9]  = '{1'b1, 1'b0, 32'h40, 1'b0, 32'h0C};
    tbl[10] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 32'h50, 1'b0, 32'h14};
    tbl[12] = '{1'b1, 1'b0, 32'h50, 1'b0, 32'h18};
    tbl[13] = '{1'b1, 1'b0, 32'h50, 1'b0, 32'h1C};
    tbl[14] = '{1'b1, 1'b1, 32'h50, 1'b0, 32'h20};

    rst = 1'b1; dq_rd_en = 1'b0; branch_valid = 1'b0; branch_target = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rd_en", icache_rd_en, 0);
    chk("rst_abort", icache_abort, 0);
    chk("rst_pc_out", icache_pc_out, 32'h0);
    chk("rst_empty", dq_empty, 1);
    chk("rst_instr", dq_instr, 0);
    chk("rst_dq_pc", dq_pc, 0);

    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dq_rd_en = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), icache_rd_en, tbl[i].exp_rd_en);
      chk($sformatf("v%0d_pc_out", i), icache_pc_out, tbl[i].exp_pc_out);
      chk($sformatf("v%0d_abort", i), icache_abort, 0);
      chk($sformatf("v%0d_empty", i), dq_empty, tbl[i].exp_empty);
      chk($sformatf("v%0d_dq_pc", i), dq_pc, tbl[i].exp_dq_pc);
      chk($sformatf("v%0d_instr", i), dq_instr, tbl[i].exp_empty ? 32'h0 : ins(tbl[i].exp_dq_pc));
      tick();
    end

    // Redirect with the credit exhausted and a return arriving; dq_rd_en in the same cycle.
    dq_rd_en = 1'b1; branch_valid = 1'b1; branch_target = 32'h0000_1238;
    @(negedge clk); chk("br_rd_en", icache_rd_en, 0);
    tick(); branch_valid = 1'b0; dq_rd_en = 1'b0;
    @(negedge clk);
    chk("redir_abort", icache_abort, 1);
    chk("redir_rd_en", icache_rd_en, 0);
    chk("redir_empty", dq_empty, 1);
    chk("redir_dq_pc", dq_pc, 0);
    tick(); @(negedge clk);
    chk("resume_rd_en", icache_rd_en, 1);
    chk("resume_pc", icache_pc_out, 32'h1230);
    chk("resume_abort", icache_abort, 0);
    tick(); @(negedge clk);
    chk("resume_pc2", icache_pc_out, 32'h1240);
    chk("resume_empty", dq_empty, 1);
    tick(); dq_rd_en = 1'b1; @(negedge clk);
    chk("br_first_pc", dq_pc, 32'h1238);
    chk("br_first_instr", dq_instr, ins(32'h1238));
    tick(); @(negedge clk);
    chk("br_second_pc", dq_pc, 32'h123C);
    tick(); @(negedge clk);
    chk("br_third_pc", dq_pc, 32'h1240);
    chk("br_third_instr", dq_instr, ins(32'h1240));
    tick(); dq_rd_en = 1'b0;

    // Fetch address wrap at the top of memory.
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFF0;
    tick(); branch_valid = 1'b0;
    @(negedge clk); chk("wrap_abort", icache_abort, 1);
    tick(); @(negedge clk);
    chk("wrap_pc_hi", icache_pc_out, 32'hFFFF_FFF0);
    chk("wrap_rd_en", icache_rd_en, 1);
    tick(); @(negedge clk);
    chk("wrap_pc_lo", icache_pc_out, 32'h0000_0000);
    tick(); @(negedge clk);
    chk("wrap_dq_pc", dq_pc, 32'hFFFF_FFF0);
    chk("wrap_instr", dq_instr, ins(32'hFFFF_FFF0));
    tick(); tick();

    // Asynchronous reset mid-stream: outputs must clear before any clock edge.
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("arst_rd_en", icache_rd_en, 0);
    chk("arst_pc_out", icache_pc_out, 32'h0);
    chk("arst_empty", dq_empty, 1);
    chk("arst_instr", dq_instr, 0);
    chk("arst_dq_pc", dq_pc, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Random traffic: q holds issue cycles of lines issued since the last redirect and
    // not yet fully consumed; a line is readable two cycles after its issue.
    now = 0; gap = 10; consumed = 0; nbr = 0; prev_br = 1'b0;
    exp_pc = 32'h0; exp_fetch = 32'h0;
    for (int it = 0; it < 4000; it++) begin
      br  = (gap >= 3) && ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      dq_rd_en      = ((it % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      branch_valid  = br;
      branch_target = tgt;
      @(negedge clk);
      exp_empty = (q.size() == 0) || (q[0] + 2 > now);
      exp_rd    = !br && !prev_br && (q.size() < DEPTH);
      if (it == 0) chk("restart_pc", icache_pc_out, 32'h0);
      chk("r_rd_en", icache_rd_en, exp_rd);
      chk("r_abort", icache_abort, prev_br);
      chk("r_empty", dq_empty, exp_empty);
      if (!exp_empty) begin
        chk("r_dq_pc", dq_pc, exp_pc);
        chk("r_instr", dq_instr, ins(exp_pc));
      end else begin
        chk("r_dq_pc_empty", dq_pc, 0);
        chk("r_instr_empty", dq_instr, 0);
      end
      if (exp_rd) chk("r_pc_out", icache_pc_out, exp_fetch);
      if (br) begin
        q.delete();
        exp_pc    = tgt & ~32'h3;
        exp_fetch = tgt & ~32'hF;
        nbr++;
      end else begin
        if (dq_rd_en && !exp_empty) begin
          if (exp_pc[3:2] == 2'd3) void'(q.pop_front());
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (exp_rd) begin
          q.push_back(now);
          exp_fetch = exp_fetch + 32'd16;
        end
      end
      prev_br = br;
      gap     = br ? 0 : gap + 1;
      now++;
      tick();
    end
    branch_valid = 1'b0; dq_rd_en = 1'b0;
    chk("liveness", 32'(consumed > 800), 1);
`ifdef IFQ_PERF_CNT_EN
    chk("perf_flush", perf_flush_cnt, 32'(nbr));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ifq_ctrl.md
Name: ifq_ctrl

Overview:
- Instruction fetch queue controller that sequences the 128-bit-line instruction cache.
- Issues line-aligned fetch addresses, buffers returned lines in a small FIFO, and hands 32-bit instructions with their PCs to dispatch.
- Handles branch redirects by flushing the queue and aborting or discarding in-flight cache reads.
- Sits between the instruction cache and decode/dispatch.

Parameters:
- DEPTH, 4: line FIFO entries; power of two, 2..16.
- CACHE_LAT, 1: cache read latency in cycles; 0 = combinational output, 1 = registered output.
- RESET_PC, 32'h0000_0000: fetch start address; bits [3:0] must be zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- icache_pc_out  out  32  fetch address to cache, always {fetch_pc[31:4],4'b0}
- icache_rd_en  out  1  cache read request
- icache_abort  out  1  cache abort
- icache_dout  in  128  returned line; word k = bits [32k+31:32k]
- icache_dout_valid  in  1  returned line valid
- branch_valid  in  1  redirect request, single-cycle pulse
- branch_target  in  32  redirect PC; bits [1:0] ignored
- dq_rd_en  in  1  dispatch consumes the current instruction
- dq_instr  out  32  current instruction
- dq_pc  out  32  PC of dq_instr
- dq_empty  out  1  no instruction available

Behaviour:
- Reset (async, on rst assertion):
  - FIFO and word pointer cleared; state = FETCH; fetch_pc = RESET_PC; start_word = 0.
  - Outputs: icache_rd_en=0, icache_abort=0, icache_pc_out=RESET_PC, dq_empty=1, dq_instr=0, dq_pc=0.
  - Reset mid-operation discards all lines and in-flight reads.
- State machine (states FETCH, REDIRECT):
  - FETCH -> REDIRECT when branch_valid.
  - REDIRECT -> FETCH unconditionally after 1 cycle.
- Issue rule: icache_rd_en = (state==FETCH) && !branch_valid && (count + inflight < DEPTH).
  - inflight = number of issued reads not yet returned: always 0 for CACHE_LAT=0, 0..1 for CACHE_LAT=1.
  - fetch_pc advances by 16 on each issue; wraps 32'hFFFF_FFF0 -> 0.
- Fill rule: a returned line is written when icache_dout_valid && state==FETCH && !branch_valid.
  - Each entry stores {line, line_pc[31:4]}.
  - A return in a branch cycle or in REDIRECT is dropped, and the inflight credit is released.
  - The FIFO never overflows: an assertion fires if a write is attempted while count==DEPTH.
- Redirect:
  - In the branch_valid cycle: FIFO flushed (count=0), word pointer := branch_target[3:2], fetch_pc := {branch_target[31:4],4'h0}, dq_rd_en ignored.
  - In REDIRECT: icache_abort=1, icache_rd_en=0.
  - The first line after a redirect starts at word branch_target[3:2]; later lines start at word 0.
- Read side:
  - dq_empty = (count==0).
  - When not empty: dq_instr = head line word[wp]; dq_pc = {head_pc, wp, 2'b00}.
  - When empty: dq_instr=0, dq_pc=0.
  - dq_rd_en while dq_empty has no effect.
  - dq_rd_en && !dq_empty: if wp==3, pop head and set wp=0; else wp+1.
- Simultaneous fill and pop on the same cycle: count unchanged; the pointers both advance.
- Fill into an empty FIFO: the instruction is visible the next cycle (no bypass).
- Steady state, dispatch consuming 1 instruction per cycle: the line supply rate of 1 per 4 cycles keeps dq_empty low once primed.

Optional Feature:
- Macro: IFQ_PERF_CNT_EN.
- Defined: adds ports perf_flush_cnt out 32 and perf_empty_cnt out 32.
  - perf_flush_cnt counts branch_valid cycles.
  - perf_empty_cnt counts cycles with dq_empty=1 after reset.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package ifq_pkg holds:
  - LINE_W=128, WORD_W=32, WORDS_PER_LINE=4, LINE_BYTES=16, LINE_PC_W=28.
  - State enum {FETCH, REDIRECT}.
  - Line-entry struct {line, line_pc}.
- Sub-module ifq_line_fifo: DEPTH x (128+28) storage with rd/wr pointers, count, flush, and async clear.
- ifq_ctrl keeps issue, credit, redirect and word-select logic.

Test Plan:
- Reset release, DEPTH=4, CACHE_LAT=1, dq_rd_en=0:
  - Exactly 4 reads issue at pc 0x00, 0x10, 0x20, 0x30, then icache_rd_en stays 0.
  - dq_pc=0x0 and dq_instr = line0 word0.
- Continuous dq_rd_en=1 after priming:
  - dq_pc sequence 0x00, 0x04, ... 0x3C with no bubbles.
  - A new read issues after each line pop.
- branch_valid with target 0x0000_1238 while the FIFO is full and a read is in flight:
  - Next cycle icache_abort=1 and dq_empty=1; the in-flight return is dropped.
  - Fetch resumes at 0x1230; first dq_pc = 0x1238, then 0x123C, then 0x1240.
- branch_valid and dq_rd_en in the same cycle: no pop occurs; only the redirect takes effect.
- Fetch at 0xFFFF_FFF0: the next issue address is 0x0000_0000.
- rst asserted mid-stream with the FIFO half full:
  - Outputs take reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
